// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button sync/debounce, press events and run/stop/clear FSM for the stopwatch counter.
// Define STOPWATCH_LAP_EN to add the lap button path and the LAP (frozen display) state.
`timescale 1ns/1ps
module stopwatch_ctrl #(
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       clear_btn,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap_btn,
`endif
    output logic       count_en,
    output logic       count_clr,
    output logic       display_hold,
    output logic [1:0] state
);
`ifdef STOPWATCH_LAP_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_TICKS - 1);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STOP = 2'b10, LAP = 2'b11} state_t;

    logic [NB-1:0] btn_raw, sync1_q, sync2_q, deb_q, deb_d, deb_prev_q, evt;
    logic [7:0]    cnt_q [NB];
    logic [7:0]    cnt_d [NB];
    state_t        state_q, state_d;
    logic          clr_q, clr_d, en_q, en_d, hold_q, hold_d;

`ifdef STOPWATCH_LAP_EN
    assign btn_raw = {lap_btn, clear_btn, stop_btn, start_btn};
`else
    assign btn_raw = {clear_btn, stop_btn, start_btn};
`endif
    assign evt = deb_q & ~deb_prev_q;

    // debounce: count ticks while the synced level disagrees, adopt it after DEBOUNCE_TICKS
    always_comb begin
        deb_d = deb_q;
        for (int b = 0; b < NB; b++) begin
            cnt_d[b] = cnt_q[b];
            if (sync2_q[b] == deb_q[b]) cnt_d[b] = 8'd0;
            else if (tick) begin
                if (cnt_q[b] == DB_LAST) begin
                    deb_d[b] = sync2_q[b];
                    cnt_d[b] = 8'd0;
                end else cnt_d[b] = cnt_q[b] + 8'd1;
            end
        end
    end

    // next state: per state, the highest-priority valid event (clear > stop > lap > start) acts
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (evt[2]) clr_d = 1'b1;
                else if (evt[0]) state_d = RUN;
            end
            RUN: begin
                if (evt[1]) state_d = STOP;
`ifdef STOPWATCH_LAP_EN
                else if (evt[3]) state_d = LAP;
`endif
            end
            STOP: begin
                if (evt[2]) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                end else if (evt[0]) state_d = RUN;
            end
`ifdef STOPWATCH_LAP_EN
            LAP: begin
                if (evt[1]) state_d = STOP;
                else if (evt[3]) state_d = RUN;
            end
`endif
            default: state_d = IDLE;
        endcase
        en_d   = (state_d == RUN) || (state_d == LAP);
`ifdef STOPWATCH_LAP_EN
        hold_d = (state_d == LAP);
`else
        hold_d = 1'b0;
`endif
    end

    // all state: synchronisers, debounce, edge history, FSM and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int b = 0; b < NB; b++) cnt_q[b] <= 8'd0;
            state_q    <= IDLE;
            clr_q      <= 1'b0;
            en_q       <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int b = 0; b < NB; b++) cnt_q[b] <= cnt_d[b];
            state_q    <= state_d;
            clr_q      <= clr_d;
            en_q       <= en_d;
            hold_q     <= hold_d;
        end
    end

    assign count_en  = en_q;
    assign count_clr = clr_q;
`ifdef STOPWATCH_LAP_EN
    assign display_hold = hold_q;
`else
    assign display_hold = 1'b0;
`endif
    assign state = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard bench for stopwatch_ctrl (DEBOUNCE_TICKS=4, tick every 10 clocks).
`timescale 1ns/1ps
module tb_stopwatch_ctrl;
    logic       clock = 1'b0, reset_n = 1'b0, tick = 1'b0;
    logic       start_btn = 1'b0, stop_btn = 1'b0, clear_btn = 1'b0;
`ifdef STOPWATCH_LAP_EN
    logic       lap_btn = 1'b0;
`endif
    logic       count_en, count_clr, display_hold;
    logic [1:0] state;
    int         total = 0, bad = 0, clr_seen = 0, lat, c0;
    logic [4:0] exp_q[$];
    logic [1:0] prev_st = 2'b00;

    stopwatch_ctrl #(.DEBOUNCE_TICKS(4)) dut (
        .clock(clock), .reset_n(reset_n), .tick(tick),
        .start_btn(start_btn), .stop_btn(stop_btn), .clear_btn(clear_btn),
`ifdef STOPWATCH_LAP_EN
        .lap_btn(lap_btn),
`endif
        .count_en(count_en), .count_clr(count_clr), .display_hold(display_hold), .state(state)
    );

    always #5 clock = ~clock;

    initial begin
        int tc = 0;
        forever begin
            @(negedge clock);
            tick = (tc == 9);
            tc = (tc == 9) ? 0 : tc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // every state change or clear pulse must match the next scoreboard entry {state,en,hold,clr}
    always @(negedge clock) begin
        if (reset_n && (state != prev_st || count_clr)) begin
            if (exp_q.size() == 0) check("unexpected_evt", exp_q.size(), 1);
            else check("evt", {state, count_en, display_hold, count_clr}, exp_q.pop_front());
        end
        if (count_clr) clr_seen++;
        prev_st <= state;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input logic [2:0] m, input int n);
        @(negedge clock);
        {clear_btn, stop_btn, start_btn} = m;
        cyc(n);
        {clear_btn, stop_btn, start_btn} = 3'b000;
        cyc(60);
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic press_lap(input int n);
        @(negedge clock);
        lap_btn = 1'b1;
        cyc(n);
        lap_btn = 1'b0;
        cyc(60);
    endtask
`endif

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clock);
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        cyc(3);
        check("rst_state", state, 0);
        check("rst_en", count_en, 0);
        check("rst_clr", count_clr, 0);
        check("rst_hold", display_hold, 0);
        reset_n = 1'b1;
        cyc(5);
        exp_q.push_back({2'b01, 1'b1, 1'b0, 1'b0});
        start_btn = 1'b1;
        lat = 0;
        while (state != 2'b01 && lat < 60) begin
            @(negedge clock);
            lat++;
        end
        check("start_latency_ok", lat <= 43, 1);
        check("run_en", count_en, 1);
        cyc(60 - lat);
        start_btn = 1'b0;
        cyc(60);
        drain("start_drain");
        press(3'b100, 50);
        check("clear_in_run", state, 1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("mid_rst_state", state, 0);
        check("mid_rst_en", count_en, 0);
        check("mid_rst_clr", count_clr, 0);
        check("mid_rst_hold", display_hold, 0);
        cyc(2);
        reset_n = 1'b1;
        cyc(5);
        exp_q.push_back({2'b01, 1'b1, 1'b0, 1'b0});
        press(3'b001, 50);
        drain("rerun_drain");
        exp_q.push_back({2'b10, 1'b0, 1'b0, 1'b0});
        press(3'b010, 50);
        drain("stop_drain");
        c0 = clr_seen;
        exp_q.push_back({2'b00, 1'b0, 1'b0, 1'b1});
        press(3'b100, 50);
        drain("clear_drain");
        check("clr_width", clr_seen - c0, 1);
        for (int k = 0; k < 4; k++) begin
            start_btn = (k % 2 == 0);
            cyc(10);
        end
        start_btn = 1'b0;
        cyc(60);
        check("bounce_state", state, 0);
        c0 = clr_seen;
        exp_q.push_back({2'b00, 1'b0, 1'b0, 1'b1});
        press(3'b100, 50);
        drain("idle_clr_drain");
        check("idle_clr_width", clr_seen - c0, 1);
        exp_q.push_back({2'b01, 1'b1, 1'b0, 1'b0});
        press(3'b001, 50);
        drain("t5_run");
        exp_q.push_back({2'b10, 1'b0, 1'b0, 1'b0});
        press(3'b010, 50);
        drain("t5_stop");
        c0 = clr_seen;
        exp_q.push_back({2'b00, 1'b0, 1'b0, 1'b1});
        press(3'b101, 50);
        drain("t5_drain");
        check("t5_clr_width", clr_seen - c0, 1);
        check("t5_state", state, 0);
        check("t5_en", count_en, 0);
`ifdef STOPWATCH_LAP_EN
        exp_q.push_back({2'b01, 1'b1, 1'b0, 1'b0});
        press(3'b001, 50);
        drain("lap_run");
        exp_q.push_back({2'b11, 1'b1, 1'b1, 1'b0});
        press_lap(50);
        drain("lap_enter");
        exp_q.push_back({2'b01, 1'b1, 1'b0, 1'b0});
        press_lap(50);
        drain("lap_exit");
        exp_q.push_back({2'b11, 1'b1, 1'b1, 1'b0});
        press_lap(50);
        drain("lap_again");
        press(3'b100, 50);
        check("lap_clear_ignored", state, 3);
        exp_q.push_back({2'b10, 1'b0, 1'b0, 1'b0});
        press(3'b010, 50);
        drain("lap_stop");
        check("lap_stop_hold", display_hold, 0);
`endif
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
